la_capture_core: RTL and testbench
==================================

Name: la_capture_core

Overview:
- Parametrised in-fabric logic-analyzer capture engine.
- Probes up to CH_W signals on one sample clock into a circular sample RAM.
- Triggers on a masked value match, with a programmable pre-trigger window.
- Streams the captured window out oldest-first over a valid/ready port to the debug/readout logic, replacing fixed 9-probe vendor capture.

Parameters:
- CH_W, 9, probe channel count (sample width).
- DEPTH, 1024, samples per capture; power of two, at least 4.
- ADDR_W, $clog2(DEPTH), RAM address width (derived; do not override).

Ports:
- clk_i  in  1  sample clock; all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- data_i  in  CH_W  probe channels.
- arm_i  in  1  single-cycle start-capture pulse.
- abort_i  in  1  single-cycle pulse; returns to IDLE from any state.
- trig_mask_i  in  CH_W  1 = channel participates in trigger.
- trig_value_i  in  CH_W  compare value for masked channels.
- pre_trig_i  in  ADDR_W  samples kept before trigger.
- armed_o  in-capture flag  out  1  high in PRE and ARMED.
- triggered_o  out  1  high from trigger until IDLE.
- done_o  out  1  high in DONE (readout phase).
- rd_valid_o  out  1  readout sample valid.
- rd_data_o  out  CH_W  readout sample.
- rd_last_o  out  1  marks final (DEPTH-th) sample.
- rd_ready_i  in  1  consumer accepts sample.

Behaviour:
- Reset: state IDLE, pointers/counters 0; all outputs 0.
- Clock and reset: one clock (clk_i); reset rst_i is synchronous, active-high.
- States: IDLE, PRE, ARMED, POST, DONE.
- IDLE:
  - arm_i -> PRE next cycle.
  - Latches pre_trig_i, trig_mask_i and trig_value_i; wr_ptr=0, cnt=0.
  - If pre_trig_i > DEPTH-1, clamp to DEPTH-1.
- PRE:
  - Writes data_i to RAM[wr_ptr] every cycle; wr_ptr++ (wraps mod DEPTH); cnt++.
  - When cnt reaches latched pre_trig -> ARMED.
  - pre_trig=0 goes straight to ARMED after zero writes, i.e. on the cycle after arm.
  - Trigger matches in PRE are ignored.
- ARMED:
  - Keeps writing circularly.
  - Match = ((data_i ^ value) & mask) == 0; a zero mask matches immediately.
  - On match: the matching sample is written, trig_ptr := wr_ptr, triggered_o=1, post_cnt := DEPTH-1-pre_trig, go POST (or DONE if post_cnt=0).
- POST:
  - Writes post_cnt further samples, then -> DONE.
  - Total written after trigger, including the trigger sample: DEPTH-pre_trig.
- DONE:
  - Writing stops; done_o=1; rd_ptr := trig_ptr - pre_trig (mod DEPTH).
  - RAM read is synchronous; rd_data_o is registered; first rd_valid_o asserts 2 cycles after entering DONE.
  - Sample advances only on rd_valid_o && rd_ready_i.
  - rd_data_o and rd_valid_o stay stable while rd_ready_i=0.
  - Prefetch keeps throughput at 1 sample/cycle with rd_ready_i held high.
  - rd_last_o is high with the DEPTH-th sample; its handshake -> IDLE; all flags clear.
- arm_i outside IDLE is ignored.
- abort_i has priority over arm_i and over any transition in the same cycle.
  - abort_i -> IDLE next cycle, flags cleared, RAM contents don't-care.
- rst_i mid-capture or mid-readout behaves as abort.

Optional Feature:
- Macro: LA_TRIG_EDGE_EN.
- Defined:
  - Extra input trig_edge_i (1 bit), latched on arm.
  - When 1, match requires the masked compare true this cycle and false the previous cycle (rising edge of the condition).
  - The previous-cycle register is cleared on entry to ARMED, so a condition already true at ARMED entry does not fire.
- Undefined: port absent; level match only.

Decomposition:
- Package la_pkg holds:
  - state enum la_state_t (IDLE, PRE, ARMED, POST, DONE);
  - state encoding constants;
  - a function computing ADDR_W.
- Sub-module la_sample_ram: simple dual-port synchronous RAM, DEPTH x CH_W, one write port and one read port, 1-cycle read latency, no reset on contents.
- FSM, counters and readout skid logic live in la_capture_core.

Test Plan:
All scenarios use CH_W=9 and DEPTH=16; data_i is a free-running counter starting at 0 on the arm cycle.
- Basic capture: pre_trig=4, mask=0x1FF, value=0x00A, arm -> triggered_o rises on the sample 0x00A; readout yields 0x006..0x015 in order, rd_last_o on 0x015, then IDLE.
- Zero pre-trigger: pre_trig=0, mask=0 -> trigger on the first ARMED sample; 16 consecutive samples read; first sample equals the trigger sample.
- Clamp and wrap: pre_trig_i=15, trigger at value 0x020 -> readout 0x011..0x020; rd_last_o on the trigger sample.
- Back-pressure: during readout drive rd_ready_i=0 for 3 cycles every 2 -> no sample dropped or duplicated; rd_data_o stable while stalled.
- Abort/reset: abort_i in POST -> IDLE next cycle, all outputs 0; arm_i pulsed during ARMED -> ignored (capture result unchanged); rst_i in DONE -> outputs 0 the next cycle.
- LA_TRIG_EDGE_EN: mask=0x001, value=0x001, edge=1, condition true at ARMED entry -> no trigger until the next 0->1 transition of bit 0.

Source files
------------

// File: rtl/la_pkg.sv
// Shared types and helpers for the la_capture_core logic-analyzer slice.
package la_pkg;

  localparam logic [2:0] LA_ENC_IDLE  = 3'd0;
  localparam logic [2:0] LA_ENC_PRE   = 3'd1;
  localparam logic [2:0] LA_ENC_ARMED = 3'd2;
  localparam logic [2:0] LA_ENC_POST  = 3'd3;
  localparam logic [2:0] LA_ENC_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = LA_ENC_IDLE,
    PRE   = LA_ENC_PRE,
    ARMED = LA_ENC_ARMED,
    POST  = LA_ENC_POST,
    DONE  = LA_ENC_DONE
  } la_state_t;

  function automatic int unsigned la_addr_w(input int unsigned depth);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/la_sample_ram.sv
// Simple dual-port sample RAM: one write port, one read port, 1-cycle read latency.
module la_sample_ram
  import la_pkg::*;
#(
  parameter int unsigned CH_W   = 9,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = la_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [CH_W-1:0]   wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [CH_W-1:0]   rdata
);

  logic [CH_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read data holds while re is low; the readout prefetch relies on this.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyzer capture engine: masked trigger, pre-trigger window, oldest-first readout.
// Define LA_TRIG_EDGE_EN to add trig_edge_i (rising-edge trigger of the match condition).
module la_capture_core
  import la_pkg::*;
#(
  parameter int unsigned CH_W   = 9,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = la_addr_w(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CH_W-1:0]   data_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [CH_W-1:0]   trig_mask_i,
  input  logic [CH_W-1:0]   trig_value_i,
  input  logic [ADDR_W-1:0] pre_trig_i,
`ifdef LA_TRIG_EDGE_EN
  input  logic              trig_edge_i,
`endif
  output logic              armed_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic              rd_valid_o,
  output logic [CH_W-1:0]   rd_data_o,
  output logic              rd_last_o,
  input  logic              rd_ready_i
);

  localparam logic [ADDR_W-1:0] PRE_MAX = ADDR_W'(DEPTH - 1);

  la_state_t         state;
  logic [ADDR_W-1:0] pre_q, wr_ptr, cnt, trig_ptr, rd_ptr;
  logic [CH_W-1:0]   mask_q, value_q, ram_q;
  logic [ADDR_W:0]   rd_issued;
  logic              q_vld, q_last;
  logic              wr_en, hit_lvl, hit, rd_load, rd_issue, rd_hs;

`ifdef LA_TRIG_EDGE_EN
  logic edge_q, prev_q, prev_vld;
`endif

  always_comb begin
    hit_lvl = ((data_i ^ value_q) & mask_q) == '0;
`ifdef LA_TRIG_EDGE_EN
    // prev_vld stays low for the first ARMED cycle so an already-true condition cannot fire.
    hit = edge_q ? (hit_lvl && prev_vld && !prev_q) : hit_lvl;
`else
    hit = hit_lvl;
`endif
    wr_en    = (state == PRE && pre_q != '0) || state == ARMED || state == POST;
    rd_hs    = rd_valid_o && rd_ready_i;
    rd_load  = q_vld && (!rd_valid_o || rd_ready_i);
    rd_issue = (state == DONE) && !rd_issued[ADDR_W] && (!q_vld || rd_load);
  end

  la_sample_ram #(
    .CH_W   (CH_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk_i),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (data_i),
    .re    (rd_issue),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      state       <= IDLE;
      pre_q       <= '0;
      mask_q      <= '0;
      value_q     <= '0;
      wr_ptr      <= '0;
      cnt         <= '0;
      trig_ptr    <= '0;
      rd_ptr      <= '0;
      rd_issued   <= '0;
      q_vld       <= 1'b0;
      q_last      <= 1'b0;
      armed_o     <= 1'b0;
      triggered_o <= 1'b0;
      done_o      <= 1'b0;
      rd_valid_o  <= 1'b0;
      rd_data_o   <= '0;
      rd_last_o   <= 1'b0;
`ifdef LA_TRIG_EDGE_EN
      edge_q      <= 1'b0;
      prev_q      <= 1'b0;
      prev_vld    <= 1'b0;
`endif
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      case (state)
        IDLE: begin
          if (arm_i) begin
            pre_q     <= (pre_trig_i > PRE_MAX) ? PRE_MAX : pre_trig_i;
            mask_q    <= trig_mask_i;
            value_q   <= trig_value_i;
            wr_ptr    <= '0;
            cnt       <= '0;
            rd_issued <= '0;
            armed_o   <= 1'b1;
            state     <= PRE;
`ifdef LA_TRIG_EDGE_EN
            edge_q    <= trig_edge_i;
`endif
          end
        end
        PRE: begin
          cnt <= cnt + 1'b1;
          if (pre_q == '0 || cnt == pre_q - 1'b1) begin
            state <= ARMED;
`ifdef LA_TRIG_EDGE_EN
            prev_vld <= 1'b0;
`endif
          end
        end
        ARMED: begin
`ifdef LA_TRIG_EDGE_EN
          prev_q   <= hit_lvl;
          prev_vld <= 1'b1;
`endif
          if (hit) begin
            trig_ptr    <= wr_ptr;
            triggered_o <= 1'b1;
            armed_o     <= 1'b0;
            cnt         <= PRE_MAX - pre_q;
            if (pre_q == PRE_MAX) begin
              rd_ptr <= wr_ptr - pre_q;
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              state <= POST;
            end
          end
        end
        POST: begin
          cnt <= cnt - 1'b1;
          if (cnt == ADDR_W'(1)) begin
            rd_ptr <= trig_ptr - pre_q;
            done_o <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          // Two-stage readout: RAM output acts as a skid slot behind the output register.
          if (rd_issue) begin
            rd_ptr    <= rd_ptr + 1'b1;
            rd_issued <= rd_issued + 1'b1;
            q_last    <= (rd_issued[ADDR_W-1:0] == '1);
            q_vld     <= 1'b1;
          end else if (rd_load) begin
            q_vld <= 1'b0;
          end
          if (rd_load) begin
            rd_valid_o <= 1'b1;
            rd_data_o  <= ram_q;
            rd_last_o  <= q_last;
          end else if (rd_hs) begin
            rd_valid_o <= 1'b0;
          end
          if (rd_hs && rd_last_o) begin
            state       <= IDLE;
            triggered_o <= 1'b0;
            done_o      <= 1'b0;
            rd_valid_o  <= 1'b0;
            rd_data_o   <= '0;
            rd_last_o   <= 1'b0;
            q_vld       <= 1'b0;
            rd_issued   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_la_capture_core.sv
// Directed table-driven bench for la_capture_core (CH_W=9, DEPTH=16); honours LA_TRIG_EDGE_EN.
module tb_la_capture_core;

  logic       clk_i = 1'b0;
  logic       rst_i, arm_i, abort_i, rd_ready_i;
  logic [8:0] data_i, trig_mask_i, trig_value_i;
  logic [3:0] pre_trig_i;
  logic       armed_o, triggered_o, done_o, rd_valid_o, rd_last_o;
  logic [8:0] rd_data_o;
`ifdef LA_TRIG_EDGE_EN
  logic       trig_edge_i;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [3:0] pre;
    logic [8:0] mask;
    logic [8:0] value;
    logic       bp;
    logic       edge_en;
    logic [8:0] rearm_at;
    logic [8:0] exp_trig;
    logic [8:0] exp_first;
  } vec_t;

  vec_t vecs[$];

  always #5 clk_i = ~clk_i;

  la_capture_core #(
    .CH_W  (9),
    .DEPTH (16)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .data_i       (data_i),
    .arm_i        (arm_i),
    .abort_i      (abort_i),
    .trig_mask_i  (trig_mask_i),
    .trig_value_i (trig_value_i),
    .pre_trig_i   (pre_trig_i),
`ifdef LA_TRIG_EDGE_EN
    .trig_edge_i  (trig_edge_i),
`endif
    .armed_o      (armed_o),
    .triggered_o  (triggered_o),
    .done_o       (done_o),
    .rd_valid_o   (rd_valid_o),
    .rd_data_o    (rd_data_o),
    .rd_last_o    (rd_last_o),
    .rd_ready_i   (rd_ready_i)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    data_i  = data_i + 9'd1;
    arm_i   = 1'b0;
    abort_i = 1'b0;
    rst_i   = 1'b0;
    @(negedge clk_i);
  endtask

  function automatic logic [13:0] outs();
    return {armed_o, triggered_o, done_o, rd_valid_o, rd_last_o, rd_data_o};
  endfunction

  task automatic start(input vec_t v);
    trig_mask_i  = v.mask;
    trig_value_i = v.value;
    pre_trig_i   = v.pre;
`ifdef LA_TRIG_EDGE_EN
    trig_edge_i  = v.edge_en;
`endif
    rd_ready_i = 1'b0;
    data_i     = '0;
    arm_i      = 1'b1;
    tick();
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int unsigned cyc, rc, idx;
    logic        seen_trig, stalled;
    logic [8:0]  held, exp_d;
    int          first_v;
    start(v);
    check($sformatf("v%0d_pre_flags", id), {armed_o, triggered_o, done_o}, 3'b100);
    seen_trig = 1'b0;
    cyc = 0;
    while (cyc < 200) begin
      if (triggered_o && !seen_trig) begin
        seen_trig = 1'b1;
        check($sformatf("v%0d_trig_sample", id), data_i - 9'd1, v.exp_trig);
      end
      if (done_o) break;
      if (v.rearm_at != 0 && data_i == v.rearm_at) arm_i = 1'b1;
      tick();
      cyc++;
    end
    check($sformatf("v%0d_trig_seen", id), seen_trig, 1);
    check($sformatf("v%0d_done", id), done_o, 1);
    rc = 0; idx = 0; first_v = -1; stalled = 1'b0; held = '0;
    while (idx < 16 && rc < 400) begin
      rd_ready_i = v.bp ? ((rc % 5) < 2) : 1'b1;
      if (rd_valid_o && first_v < 0) begin
        first_v = rc;
        check($sformatf("v%0d_first_latency", id), rc, 2);
      end
      if (stalled)
        check($sformatf("v%0d_hold_%0d", id, idx), {rd_valid_o, rd_data_o}, {1'b1, held});
      if (rd_valid_o && rd_ready_i) begin
        exp_d = v.exp_first + idx[8:0];
        check($sformatf("v%0d_sample_%0d", id, idx), {rd_last_o, rd_data_o}, {(idx == 15), exp_d});
        idx++;
      end
      stalled = rd_valid_o && !rd_ready_i;
      held    = rd_data_o;
      tick();
      rc++;
    end
    check($sformatf("v%0d_sample_count", id), idx, 16);
    if (!v.bp) check($sformatf("v%0d_throughput", id), rc, 18);
    rd_ready_i = 1'b0;
    check($sformatf("v%0d_idle_after", id), outs(), 0);
  endtask

  task automatic wait_trig(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (triggered_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    logic ok;
    rst_i = 1'b1; arm_i = 1'b0; abort_i = 1'b0; rd_ready_i = 1'b0;
    data_i = '0; trig_mask_i = '0; trig_value_i = '0; pre_trig_i = '0;
`ifdef LA_TRIG_EDGE_EN
    trig_edge_i = 1'b0;
`endif
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_outputs", outs(), 0);
    tick();

    //              pre    mask     value   bp    edge  rearm   trig    first
    vecs.push_back('{4'd4,  9'h1FF, 9'h00A, 1'b0, 1'b0, 9'd0,  9'h00A, 9'h006});
    vecs.push_back('{4'd0,  9'h000, 9'h000, 1'b0, 1'b0, 9'd0,  9'h002, 9'h002});
    vecs.push_back('{4'd15, 9'h1FF, 9'h020, 1'b0, 1'b0, 9'd0,  9'h020, 9'h011});
    vecs.push_back('{4'd4,  9'h1FF, 9'h00A, 1'b1, 1'b0, 9'd0,  9'h00A, 9'h006});
    vecs.push_back('{4'd7,  9'h0F0, 9'h030, 1'b0, 1'b0, 9'd0,  9'h030, 9'h029});
    vecs.push_back('{4'd4,  9'h1FF, 9'h00A, 1'b0, 1'b0, 9'd7,  9'h00A, 9'h006});
`ifdef LA_TRIG_EDGE_EN
    vecs.push_back('{4'd4,  9'h001, 9'h001, 1'b0, 1'b1, 9'd0,  9'h007, 9'h003});
`endif

    foreach (vecs[i]) begin
      run_vec(vecs[i], i);
      tick();
    end

    // abort while in POST
    start(vecs[0]);
    wait_trig(ok);
    check("abort_trig_seen", ok, 1);
    tick();
    check("abort_in_post", {triggered_o, done_o}, 2'b10);
    abort_i = 1'b1;
    tick();
    check("abort_outputs", outs(), 0);
    repeat (3) tick();
    check("abort_stays_idle", outs(), 0);

    // reset during readout
    start(vecs[0]);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rd_valid_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("rst_valid_seen", {ok, done_o}, 2'b11);
    rst_i = 1'b1;
    tick();
    check("rst_in_done_outputs", outs(), 0);
    tick();

    run_vec(vecs[0], 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
